// File: rtl/rns_reverse_converter.sv
`default_nettype none
// ============================================================================
// rns_reverse_converter : {8,7,5} residue-to-binary converter, mixed-radix FSM
// Revision 1.0
// ============================================================================
module rns_reverse_converter #(
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] r8,
  input  logic [2:0] r7,
  input  logic [2:0] r5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] x,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A2   = 3'd1,
    A3A  = 3'd2,
    A3B  = 3'd3,
    SUM  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] cap8, cap7, cap5;
  logic       cap_err;
  logic [2:0] a2, t, a3;

  // (a - b) mod m for a, b < m: two's-complement difference, add m back on borrow
  function automatic logic [2:0] sub_mod(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] m);
    logic [3:0] d;
    d = {1'b0, a} + {1'b1, ~b} + 4'd1;
    if (d[3]) d = d + {1'b0, m};
    return d[2:0];
  endfunction

  function automatic logic [2:0] mul2_mod5(input logic [2:0] v);
    case (v)
      3'd1:    return 3'd2;
      3'd2:    return 3'd4;
      3'd3:    return 3'd1;
      3'd4:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] mul3_mod5(input logic [2:0] v);
    case (v)
      3'd1:    return 3'd3;
      3'd2:    return 3'd1;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] a1_m7, a1_m5, a2_m5;
  logic [5:0] hi;
  logic [8:0] x_bin;
  logic [9:0] x_mapped;

  assign a1_m7 = (cap8 == 3'd7) ? 3'd0 : cap8;
  assign a1_m5 = (cap8 >= 3'd5) ? cap8 - 3'd5 : cap8;
  assign a2_m5 = (a2 >= 3'd5) ? a2 - 3'd5 : a2;

  // X = a1 + 8*(a2 + 7*a3); 7*a3 formed as (a3 << 3) - a3
  assign hi    = {3'b000, a2} + {a3, 3'b000} - {3'b000, a3};
  assign x_bin = {hi, cap8};

  generate
    if (SIGNED_OUT) begin : g_signed
      assign x_mapped = (x_bin >= 9'd140) ? ({1'b0, x_bin} + 10'd744) : {1'b0, x_bin};
    end else begin : g_unsigned
      assign x_mapped = {1'b0, x_bin};
    end
  endgenerate

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      x         <= 10'd0;
      err       <= 1'b0;
      cap8      <= 3'd0;
      cap7      <= 3'd0;
      cap5      <= 3'd0;
      cap_err   <= 1'b0;
      a2        <= 3'd0;
      t         <= 3'd0;
      a3        <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap8    <= r8;
            cap7    <= r7;
            cap5    <= r5;
            cap_err <= (r7 == 3'd7) || (r5 >= 3'd5);
            state   <= A2;
          end
        end
        A2: begin
          a2    <= sub_mod(cap7, a1_m7, 3'd7);
          state <= A3A;
        end
        A3A: begin
          t     <= mul2_mod5(sub_mod(cap5, a1_m5, 3'd5));
          state <= A3B;
        end
        A3B: begin
          a3    <= mul3_mod5(sub_mod(t, a2_m5, 3'd5));
          state <= SUM;
        end
        SUM: begin
          x         <= cap_err ? 10'd0 : x_mapped;
          err       <= cap_err;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
